add_share_arbiter: RTL

- Shares one WIDTH-bit adder (A+B with carry-out) among NREQ requesters.
- Round-robin grant with a valid/ready handshake on every port.
- One registered result stage that carries the granted requester ID.
- Sits between the user-logic requesters and the top-level pin mapping; sequences all traffic through the single adder datapath.

---
 rtl/add_share_pkg.sv | 13 +
 rtl/add_share_arbiter_rr.sv | 42 ++++
 rtl/add_share_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/add_share_pkg.sv
// Shared definitions for the add_share_arbiter slice.
// Holds the default sizing constants, the operation-counter width and the
// requester ID type for the default configuration.
package add_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W = 16;
    localparam int IDW_DEF = $clog2(NREQ_DEF);

    typedef logic [IDW_DEF-1:0] req_id_t;

endpackage

// File: rtl/add_share_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin arbiter.
// Ports:
//   req        in   NREQ  request vector
//   ptr        in   IDW   index of the most recent grant; search starts at ptr+1
//   gnt_onehot out  NREQ  one-hot grant (all zero when nothing requests)
//   gnt_idx    out  IDW   index of the granted requester (0 when nothing requests)
//   any        out  1     at least one request is present
module rr_arbiter
    import add_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Walk the indices ptr+1, ptr+2, ... wrapping modulo NREQ, and take the
    // first one that requests. ptr itself is visited last, so the previous
    // winner has lowest priority.
    always_comb begin : search
        int unsigned idx;
        logic found;
        gnt_onehot = '0;
        gnt_idx = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one WIDTH-bit adder shared by NREQ requesters through a
// round-robin arbiter, with a single registered result stage tagged with the
// requester ID.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid/ready per-requester handshake
//   req_a, req_b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready result handshake
//   rsp_sum         (A+B) mod 2^WIDTH
//   rsp_carry       carry-out of A+B
//   rsp_id          requester that produced the result
//   op_count        accepted operations, wraps modulo 2^16
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id,
    output logic [CNT_W-1:0]  op_count
);

    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  gnt_onehot;
    logic [IDW-1:0]   gnt_idx;
    logic             any;
    logic             can_acc;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum_full;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // The result register can take a new value when it is empty or is being
    // drained this same cycle; that is what gives one op per cycle.
    assign can_acc = !rsp_valid || rsp_ready;
    assign accept = can_acc && any;
    assign req_ready = accept ? gnt_onehot : '0;

    // One-hot operand mux feeding the single shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    // rr_ptr resets to NREQ-1 so the first search starts at requester 0.
    // Without an accept, a consumed result only clears rsp_valid; the data
    // fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum <= '0;
            rsp_carry <= 1'b0;
            rsp_id <= '0;
            rr_ptr <= IDW'(NREQ - 1);
            op_count <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            {rsp_carry, rsp_sum} <= sum_full;
            rsp_id <= gnt_idx;
            rr_ptr <= gnt_idx;
            op_count <= op_count + 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
